// File: rtl/mul_div_seq.sv
// RV32M/RV64M multiply/divide unit: MUL ops complete in MUL_STAGES cycles, divides in 2+XLEN/DIV_RADIX_BITS.
// Special-case divides complete in 1 cycle. start is ignored while busy. kill flushes the op in flight.
module mul_div_seq #(
   parameter int XLEN           = 32,
   parameter int MUL_STAGES     = 1,
   parameter int DIV_RADIX_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      opcode,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            ready,
   output logic [XLEN-1:0] result
);
   localparam int ITERS = XLEN / DIV_RADIX_BITS;
   localparam int CW    = $clog2(ITERS) + 1;
   localparam int PL    = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_MUL    = 3'd1;
   localparam logic [2:0] S_DSETUP = 3'd2;
   localparam logic [2:0] S_DITER  = 3'd3;
   localparam logic [2:0] S_DFIX   = 3'd4;
   localparam logic [2:0] S_DSPEC  = 3'd5;

   logic [2:0]                state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [1:0]                op_q, op_d;
   logic [XLEN-1:0]           a_q, a_d, b_q, b_d, rem_q, rem_d, result_q, result_d;
   logic                      qneg_q, qneg_d, rneg_q, rneg_d, ready_q, ready_d;
   logic [PL-1:0][2*XLEN-1:0] prod_q, prod_d;

   logic                      mul_sa, mul_sb, div_sgn, spec_in;
   logic [2*XLEN-1:0]         prod_full, prod_src;
   logic [XLEN-1:0]           mul_res, spec_res, fix_res, q_fix, r_fix, it_q, it_r;

   // Operands are sign- or zero-extended to 2*XLEN so one unsigned multiply covers all signedness mixes.
   assign mul_sa    = (op_q == 2'b01) || (op_q == 2'b10);
   assign mul_sb    = (op_q == 2'b01);
   assign prod_full = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q} * {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
   assign prod_src  = (MUL_STAGES == 1) ? prod_full : prod_q[PL-1];
   assign mul_res   = (op_q == 2'b00) ? prod_src[XLEN-1:0] : prod_src[2*XLEN-1:XLEN];

   assign spec_in  = (rs2 == '0) || (!opcode[0] && (rs1 == MIN_NEG) && (rs2 == '1));
   assign spec_res = (b_q == '0) ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : a_q);
   assign div_sgn  = ~op_q[0];

   assign q_fix   = qneg_q ? -a_q : a_q;
   assign r_fix   = rneg_q ? -rem_q : rem_q;
   assign fix_res = op_q[1] ? r_fix : q_fix;

   // a_q doubles as the dividend/quotient shift register; b_q holds the divisor magnitude.
   always_comb begin
      logic [XLEN:0] diff;
      diff = '0;
      it_q = a_q;
      it_r = rem_q;
      for (int i = 0; i < DIV_RADIX_BITS; i++) begin
         diff = {it_r, it_q[XLEN-1]} - {1'b0, b_q};
         it_r = diff[XLEN] ? {it_r[XLEN-2:0], it_q[XLEN-1]} : diff[XLEN-1:0];
         it_q = {it_q[XLEN-2:0], ~diff[XLEN]};
      end
   end

   always_comb begin
      prod_d    = prod_q;
      prod_d[0] = prod_full;
      for (int i = 1; i < PL; i++) begin
         prod_d[i] = prod_q[i-1];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      ready_d  = 1'b0;
      if (kill) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_d = opcode[1:0];
                  a_d  = rs1;
                  b_d  = rs2;
                  if (!opcode[2]) begin
                     state_d = S_MUL;
                     cnt_d   = CW'(MUL_STAGES - 1);
                  end else if (spec_in) begin
                     state_d = S_DSPEC;
                  end else begin
                     state_d = S_DSETUP;
                  end
               end
            end
            S_MUL: begin
               if (cnt_q == '0) begin
                  state_d  = S_IDLE;
                  ready_d  = 1'b1;
                  result_d = mul_res;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_DSPEC: begin
               state_d  = S_IDLE;
               ready_d  = 1'b1;
               result_d = spec_res;
            end
            S_DSETUP: begin
               a_d     = (div_sgn & a_q[XLEN-1]) ? -a_q : a_q;
               b_d     = (div_sgn & b_q[XLEN-1]) ? -b_q : b_q;
               rem_d   = '0;
               qneg_d  = div_sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
               rneg_d  = div_sgn & a_q[XLEN-1];
               cnt_d   = CW'(ITERS - 1);
               state_d = S_DITER;
            end
            S_DITER: begin
               a_d   = it_q;
               rem_d = it_r;
               if (cnt_q == '0) begin
                  state_d = S_DFIX;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_DFIX: begin
               state_d  = S_IDLE;
               ready_d  = 1'b1;
               result_d = fix_res;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         prod_q   <= prod_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign ready  = ready_q;
   assign result = result_q;
endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: a default 32-bit instance plus a 64-bit, radix-4, 3-stage instance,
// both checked against a wide-integer RISC-V M reference model.
module tb_mul_div_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, kill, busy, ready;
   logic [2:0]  opcode;
   logic [31:0] rs1, rs2, result;
   logic        start_w, kill_w, busy_w, ready_w;
   logic [2:0]  opcode_w;
   logic [63:0] rs1_w, rs2_w, result_w;

   int n_chk  = 0;
   int n_fail = 0;

   mul_div_seq #(.XLEN(32), .MUL_STAGES(1), .DIV_RADIX_BITS(1)) dut (
      .clk(clk), .rst(rst), .start(start), .kill(kill), .opcode(opcode),
      .rs1(rs1), .rs2(rs2), .busy(busy), .ready(ready), .result(result));

   mul_div_seq #(.XLEN(64), .MUL_STAGES(3), .DIV_RADIX_BITS(2)) dut_w (
      .clk(clk), .rst(rst), .start(start_w), .kill(kill_w), .opcode(opcode_w),
      .rs1(rs1_w), .rs2(rs2_w), .busy(busy_w), .ready(ready_w), .result(result_w));

   function automatic logic [63:0] xmask(input int xl);
      return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] model(input int xl, input logic [2:0] op,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask;
      logic signed [129:0] ua, ub, sa, sb, p;
      mask = xmask(xl);
      ua = {66'd0, a & mask};
      ub = {66'd0, b & mask};
      sa = a[xl-1] ? ua - (130'sd1 <<< xl) : ua;
      sb = b[xl-1] ? ub - (130'sd1 <<< xl) : ub;
      case (op)
         3'b000:  p = sa * sb;
         3'b001:  p = (sa * sb) >>> xl;
         3'b010:  p = (sa * ub) >>> xl;
         3'b011:  p = (ua * ub) >>> xl;
         3'b100:  p = (ub == 0) ? -130'sd1 : sa / sb;
         3'b101:  p = (ub == 0) ? -130'sd1 : ua / ub;
         3'b110:  p = (ub == 0) ? sa : sa % sb;
         default: p = (ub == 0) ? ua : ua % ub;
      endcase
      return p[63:0] & mask;
   endfunction

   function automatic int exp_lat(input int xl, input int ms, input int rb, input logic [2:0] op,
                                  input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask;
      mask = xmask(xl);
      if (!op[2]) return ms;
      if ((b & mask) == 64'd0) return 1;
      if (!op[0] && ((a & mask) == (64'd1 << (xl - 1))) && ((b & mask) == mask)) return 1;
      return 2 + xl / rb;
   endfunction

   function automatic logic [63:0] pick(input int xl);
      logic [63:0] v;
      case ($urandom_range(0, 6))
         0:       v = 64'd0;
         1:       v = xmask(xl);
         2:       v = 64'd1 << (xl - 1);
         3:       v = 64'($urandom_range(1, 9));
         default: v = {32'($urandom), 32'($urandom)} & xmask(xl);
      endcase
      return v;
   endfunction

   // lat counts clock edges from the accept edge to the edge that raised ready.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      @(negedge clk);
      start = 1'b1; opcode = op; rs1 = a; rs2 = b;
      @(negedge clk);
      start = 1'b0; opcode = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      lat = 0;
      while (ready !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = result;
   endtask

   task automatic run_op_w(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] res, output int lat);
      @(negedge clk);
      start_w = 1'b1; opcode_w = op; rs1_w = a; rs2_w = b;
      @(negedge clk);
      start_w = 1'b0; opcode_w = 3'($urandom); rs1_w = {$urandom, $urandom}; rs2_w = {$urandom, $urandom};
      lat = 0;
      while (ready_w !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = result_w;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; kill = 1'b0; opcode = '0; rs1 = '0; rs2 = '0;
      start_w = 1'b0; kill_w = 1'b0; opcode_w = '0; rs1_w = '0; rs2_w = '0;
      repeat (3) @(negedge clk);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_chk++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
      n_chk++; if (busy_w !== 1'b0 || ready_w !== 1'b0 || result_w !== 64'd0) begin
         n_fail++; $display("FAIL reset_wide: busy %b ready %b result %h want all 0", busy_w, ready_w, result_w);
      end
      rst = 1'b0;
   endtask

   task automatic test_mul();
      logic [2:0]  t_op[4];
      logic [31:0] t_a[4], t_b[4], t_e[4];
      logic [31:0] res;
      logic [63:0] a, b, e;
      logic [2:0]  op;
      int          lat;
      t_op = '{3'b000, 3'b001, 3'b011, 3'b010};
      t_a  = '{32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      t_b  = '{32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      t_e  = '{32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], res, lat);
         n_chk++; if (res !== t_e[i]) begin n_fail++; $display("FAIL mul_dir%0d: got %h want %h", i, res, t_e[i]); end
         n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL mul_lat%0d: got %0d want 1", i, lat); end
      end
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 3)); a = pick(32); b = pick(32);
         e = model(32, op, a, b);
         run_op(op, a[31:0], b[31:0], res, lat);
         n_chk++; if (res !== e[31:0]) begin
            n_fail++; $display("FAIL mul_rand op%0d %h*%h: got %h want %h", op, a[31:0], b[31:0], res, e[31:0]);
         end
         n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL mul_rand_lat: got %0d want 1", lat); end
      end
   endtask

   task automatic test_div();
      logic [2:0]  t_op[6];
      logic [31:0] t_a[6], t_e[6];
      logic [31:0] res;
      logic [63:0] a, b, e;
      logic [2:0]  op;
      int          lat, el;
      t_op = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b110};
      t_a  = '{32'd100, 32'd100, 32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
      t_e  = '{32'hE, 32'hE, 32'h2, 32'h2, 32'hFFFF_FFF2, 32'hFFFF_FFFE};
      for (int i = 0; i < 6; i++) begin
         run_op(t_op[i], t_a[i], 32'd7, res, lat);
         n_chk++; if (res !== t_e[i]) begin n_fail++; $display("FAIL div_dir%0d: got %h want %h", i, res, t_e[i]); end
         n_chk++; if (lat !== 34) begin n_fail++; $display("FAIL div_lat%0d: got %0d want 34", i, lat); end
         @(negedge clk);
         n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL div_ready_pulse%0d: got %b want 0", i, ready); end
      end
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(4, 7)); a = pick(32); b = pick(32);
         e  = model(32, op, a, b);
         el = exp_lat(32, 1, 1, op, a, b);
         run_op(op, a[31:0], b[31:0], res, lat);
         n_chk++; if (res !== e[31:0]) begin
            n_fail++; $display("FAIL div_rand op%0d %h,%h: got %h want %h", op, a[31:0], b[31:0], res, e[31:0]);
         end
         n_chk++; if (lat !== el) begin n_fail++; $display("FAIL div_rand_lat: got %0d want %0d", lat, el); end
      end
   endtask

   task automatic test_special();
      logic [2:0]  t_op[6];
      logic [31:0] t_a[6], t_b[6], t_e[6];
      logic [31:0] res;
      int          lat;
      t_op = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
      t_a  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFFD};
      t_b  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      t_e  = '{32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      for (int i = 0; i < 6; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], res, lat);
         n_chk++; if (res !== t_e[i]) begin n_fail++; $display("FAIL spec%0d: got %h want %h", i, res, t_e[i]); end
         n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL spec_lat%0d: got %0d want 1", i, lat); end
      end
   endtask

   task automatic test_kill();
      logic [31:0] res;
      int          k, lat, pulses;
      @(negedge clk);
      start = 1'b1; opcode = 3'b100; rs1 = 32'd100; rs2 = 32'd7;
      @(negedge clk);
      start = 1'b0; rs1 = 32'd999; rs2 = 32'd1;
      repeat (4) @(negedge clk);
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_div: got %b want 1", busy); end
      start = 1'b1; opcode = 3'b000; rs1 = 32'd55;
      @(negedge clk);
      start = 1'b0;
      k = 5;
      while (ready !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_chk++; if (result !== 32'hE) begin n_fail++; $display("FAIL start_ignored: got %h want e", result); end
      n_chk++; if (k !== 34) begin n_fail++; $display("FAIL start_ignored_lat: got %0d want 34", k); end

      @(negedge clk);
      start = 1'b1; opcode = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b want 0", busy); end
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready === 1'b1) pulses++;
      end
      n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL kill_no_ready: got %0d pulses want 0", pulses); end
      n_chk++; if (result !== 32'hE) begin n_fail++; $display("FAIL kill_result_held: got %h want e", result); end

      run_op(3'b000, 32'd3, 32'd4, res, lat);
      n_chk++; if (res !== 32'hC) begin n_fail++; $display("FAIL mul_after_kill: got %h want c", res); end

      @(negedge clk);
      start = 1'b1; kill = 1'b1; opcode = 3'b000; rs1 = 32'd5; rs2 = 32'd5;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_start_busy: got %b want 0", busy); end
      @(negedge clk);
      n_chk++; if (ready !== 1'b0 || result !== 32'hC) begin
         n_fail++; $display("FAIL kill_start_dropped: ready %b result %h want 0 c", ready, result);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      @(negedge clk);
      start = 1'b1; opcode = 3'b100; rs1 = 32'd100; rs2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++; if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0) begin
         n_fail++; $display("FAIL reset_mid: busy %b ready %b result %h want 0 0 0", busy, ready, result);
      end
      pulses = 0;
      repeat (30) begin
         @(negedge clk);
         if (ready === 1'b1) pulses++;
      end
      n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL reset_mid_no_ready: got %0d want 0", pulses); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      start = 1'b1; opcode = 3'b000; rs1 = 32'd6; rs2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_chk++; if (ready !== 1'b1 || result !== 32'd42) begin
         n_fail++; $display("FAIL b2b_first: ready %b result %h want 1 2a", ready, result);
      end
      start = 1'b1; opcode = 3'b000; rs1 = 32'd9; rs2 = 32'd9;
      @(negedge clk);
      start = 1'b0;
      n_chk++; if (busy !== 1'b1 || ready !== 1'b0) begin
         n_fail++; $display("FAIL b2b_accept: busy %b ready %b want 1 0", busy, ready);
      end
      @(negedge clk);
      n_chk++; if (ready !== 1'b1 || result !== 32'd81) begin
         n_fail++; $display("FAIL b2b_second: ready %b result %h want 1 51", ready, result);
      end
   endtask

   task automatic test_sweep();
      logic [63:0] a, b, e, res;
      logic [2:0]  op;
      int          lat, el;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7)); a = pick(64); b = pick(64);
         e  = model(64, op, a, b);
         el = exp_lat(64, 3, 2, op, a, b);
         run_op_w(op, a, b, res, lat);
         n_chk++; if (res !== e) begin
            n_fail++; $display("FAIL wide op%0d %h,%h: got %h want %h", op, a, b, res, e);
         end
         n_chk++; if (lat !== el) begin n_fail++; $display("FAIL wide_lat op%0d: got %0d want %0d", op, lat, el); end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_kill();
      test_reset_mid();
      test_back_to_back();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
